lat_stats_accum: RTL and testbench



---
 rtl/lat_stats_pkg.sv | 35 +++
 rtl/lat_stats_sat_add.sv | 32 +++
 rtl/lat_stats_accum.sv | 188 ++++++++++++++++++
 tb/tb_lat_stats_accum.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lat_stats_pkg.sv
// ----------------------------------------------------------------------------
// lat_stats_pkg
// Definitions shared by the latency statistics accumulator and its
// saturating adder:
//   - state_e   : snapshot FSM states (ST_IDLE, ST_HOLD)
//   - SEQ_W     : width of the snapshot sequence number
//   - sat_add_u : unsigned add of two operands up to 64 bits wide that clamps
//                 at all-ones of width w and reports whether it clamped
// ----------------------------------------------------------------------------
package lat_stats_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam int SEQ_W = 4;

    // Operands are zero-extended to 64 bits by the caller, so w must be in
    // 1..64. ovf is set when the true sum exceeds all-ones of width w.
    function automatic logic [63:0] sat_add_u(
        input  logic [63:0] a,
        input  logic [63:0] b,
        input  int unsigned w,
        output logic        ovf
    );
        logic [64:0] full;
        logic [63:0] lim;
        full = {1'b0, a} + {1'b0, b};
        lim  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        ovf  = (full > {1'b0, lim});
        return ovf ? lim : full[63:0];
    endfunction

endpackage

// File: rtl/lat_stats_sat_add.sv
// ----------------------------------------------------------------------------
// lat_stats_sat_add
// Combinational unsigned adder that clamps at all-ones of W bits.
// Ports:
//   i_a, i_b : W-bit unsigned operands
//   o_sum    : i_a + i_b, clamped to all-ones on overflow
//   o_sat    : 1 when the true sum did not fit in W bits
// W must be in 1..64.
// ----------------------------------------------------------------------------
module lat_stats_sat_add
    import lat_stats_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_sat
);

    logic w_ovf;

    // NOTE: combinational logic uses blocking '=' and gives every output a
    // default at the top of the block, so no path leaves a value unassigned
    // and no latch is inferred.
    always_comb begin
        w_ovf = 1'b0;
        o_sum = W'(sat_add_u(64'(i_a), 64'(i_b), W, w_ovf));
        o_sat = w_ovf;
    end

endmodule

// File: rtl/lat_stats_accum.sv
// ----------------------------------------------------------------------------
// lat_stats_accum
// Latency statistics accumulator in the datapath clock domain. Tracks live
// min/max/sum/count of per-packet latency samples and, on request, freezes
// them into a snapshot bus held stable for at least HOLD_CYC cycles so a
// downstream bus synchronizer can capture a coherent word.
// Ports:
//   clk, reset    : datapath clock, asynchronous active-high reset
//   sample_valid  : qualifies sample_lat for one cycle
//   sample_lat    : latency sample (LAT_W bits, unsigned)
//   clear         : pulse; reinitialises live accumulators (wins over snap_req)
//   snap_req      : pulse; snapshot-and-clear, ignored while snap_busy
//   snap_busy     : high for exactly HOLD_CYC cycles after a snapshot
//   snap_min/max/sum/cnt/sat : frozen statistics of the last interval
//   snap_seq      : snapshot sequence number, wraps 15 -> 0
// All outputs are registers; SUM_W must be >= LAT_W and HOLD_CYC >= 2.
// ----------------------------------------------------------------------------
module lat_stats_accum
    import lat_stats_pkg::*;
#(
    parameter int LAT_W    = 16,
    parameter int CNT_W    = 32,
    parameter int SUM_W    = 48,
    parameter int HOLD_CYC = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [LAT_W-1:0] sample_lat,
    input  logic             clear,
    input  logic             snap_req,
    output logic             snap_busy,
    output logic [LAT_W-1:0] snap_min,
    output logic [LAT_W-1:0] snap_max,
    output logic [SUM_W-1:0] snap_sum,
    output logic [CNT_W-1:0] snap_cnt,
    output logic             snap_sat,
    output logic [SEQ_W-1:0] snap_seq
);

    localparam int HOLD_W = $clog2(HOLD_CYC);

    // Live accumulators
    logic [LAT_W-1:0]  r_min;
    logic [LAT_W-1:0]  r_max;
    logic [SUM_W-1:0]  r_sum;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sat;

    // Snapshot FSM and frozen outputs
    state_e            r_state;
    logic              r_busy;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [LAT_W-1:0]  r_snap_min;
    logic [LAT_W-1:0]  r_snap_max;
    logic [SUM_W-1:0]  r_snap_sum;
    logic [CNT_W-1:0]  r_snap_cnt;
    logic              r_snap_sat;
    logic [SEQ_W-1:0]  r_snap_seq;

    // Saturating adders for sum and count
    logic [SUM_W-1:0]  w_sum_add;
    logic              w_sum_ovf;
    logic [CNT_W-1:0]  w_cnt_add;
    logic              w_cnt_ovf;

    // Live values with the current cycle's sample folded in
    logic [LAT_W-1:0]  w_upd_min;
    logic [LAT_W-1:0]  w_upd_max;
    logic [SUM_W-1:0]  w_upd_sum;
    logic [CNT_W-1:0]  w_upd_cnt;
    logic              w_upd_sat;
    logic              w_upd_empty;
    logic              w_accept;

    lat_stats_sat_add #(.W(SUM_W)) u_sum_add (
        .i_a   (r_sum),
        .i_b   (SUM_W'(sample_lat)),
        .o_sum (w_sum_add),
        .o_sat (w_sum_ovf)
    );

    lat_stats_sat_add #(.W(CNT_W)) u_cnt_add (
        .i_a   (r_cnt),
        .i_b   (CNT_W'(1)),
        .o_sum (w_cnt_add),
        .o_sat (w_cnt_ovf)
    );

    always_comb begin
        w_upd_min = r_min;
        w_upd_max = r_max;
        w_upd_sum = r_sum;
        w_upd_cnt = r_cnt;
        w_upd_sat = r_sat;
        if (sample_valid) begin
            w_upd_min = (sample_lat < r_min) ? sample_lat : r_min;
            w_upd_max = (sample_lat > r_max) ? sample_lat : r_max;
            w_upd_sum = w_sum_add;
            w_upd_cnt = w_cnt_add;
            w_upd_sat = r_sat | w_sum_ovf | w_cnt_ovf;
        end
    end

    // The snapshot sees the coincident sample, so it is built from the
    // updated values. An empty interval reports min = max = 0 rather than
    // the all-ones min seed.
    assign w_upd_empty = (w_upd_cnt == '0);
    assign w_accept    = (r_state == ST_IDLE) && snap_req && !clear;

    // Live accumulators: clear and an accepted snapshot both restart the
    // interval; a sample arriving with either is not carried into the new one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_min <= '1;
            r_max <= '0;
            r_sum <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (clear || w_accept) begin
            r_min <= '1;
            r_max <= '0;
            r_sum <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else begin
            r_min <= w_upd_min;
            r_max <= w_upd_max;
            r_sum <= w_upd_sum;
            r_cnt <= w_upd_cnt;
            r_sat <= w_upd_sat;
        end
    end

    // Snapshot FSM. The hold counter is loaded with HOLD_CYC-1 on entry and
    // the FSM leaves HOLD on the edge after it reaches 0, giving exactly
    // HOLD_CYC busy cycles. clear does not touch this block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_hold_cnt <= '0;
            r_snap_min <= '0;
            r_snap_max <= '0;
            r_snap_sum <= '0;
            r_snap_cnt <= '0;
            r_snap_sat <= 1'b0;
            r_snap_seq <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_HOLD;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= HOLD_W'(HOLD_CYC - 1);
                        r_snap_min <= w_upd_empty ? '0 : w_upd_min;
                        r_snap_max <= w_upd_empty ? '0 : w_upd_max;
                        r_snap_sum <= w_upd_sum;
                        r_snap_cnt <= w_upd_cnt;
                        r_snap_sat <= w_upd_sat;
                        r_snap_seq <= r_snap_seq + SEQ_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign snap_busy = r_busy;
    assign snap_min  = r_snap_min;
    assign snap_max  = r_snap_max;
    assign snap_sum  = r_snap_sum;
    assign snap_cnt  = r_snap_cnt;
    assign snap_sat  = r_snap_sat;
    assign snap_seq  = r_snap_seq;

endmodule

// File: tb/tb_lat_stats_accum.sv
// ----------------------------------------------------------------------------
// tb_lat_stats_accum
// Directed bench for lat_stats_accum. Instance u_dut_a uses default widths
// and is driven through tick(), which runs a reference model, queues the
// expected snapshot when an accepted snap_req is driven and compares it when
// the DUT presents it one cycle later. Instance u_dut_b (SUM_W = 18) covers
// sum saturation with fixed expected values.
// ----------------------------------------------------------------------------
module tb_lat_stats_accum;
    import lat_stats_pkg::*;

    localparam int LAT_W    = 16;
    localparam int CNT_W    = 32;
    localparam int SUM_W    = 48;
    localparam int HOLD_CYC = 16;
    localparam int SUM_W_B  = 18;

    typedef struct {
        logic [LAT_W-1:0] mn;
        logic [LAT_W-1:0] mx;
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] cnt;
        logic             sat;
        logic [SEQ_W-1:0] seq;
    } snap_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT A
    logic             a_valid, a_clear, a_req;
    logic [LAT_W-1:0] a_lat;
    logic             a_busy, a_sat;
    logic [LAT_W-1:0] a_min, a_max;
    logic [SUM_W-1:0] a_sum;
    logic [CNT_W-1:0] a_cnt;
    logic [SEQ_W-1:0] a_seq;

    // DUT B
    logic               b_valid, b_clear, b_req;
    logic [LAT_W-1:0]   b_lat;
    logic               b_busy, b_sat;
    logic [LAT_W-1:0]   b_min, b_max;
    logic [SUM_W_B-1:0] b_sum;
    logic [CNT_W-1:0]   b_cnt;
    logic [SEQ_W-1:0]   b_seq;

    lat_stats_accum #(
        .LAT_W(LAT_W), .CNT_W(CNT_W), .SUM_W(SUM_W), .HOLD_CYC(HOLD_CYC)
    ) u_dut_a (
        .clk(clk), .reset(reset),
        .sample_valid(a_valid), .sample_lat(a_lat),
        .clear(a_clear), .snap_req(a_req),
        .snap_busy(a_busy), .snap_min(a_min), .snap_max(a_max),
        .snap_sum(a_sum), .snap_cnt(a_cnt), .snap_sat(a_sat), .snap_seq(a_seq)
    );

    lat_stats_accum #(
        .LAT_W(LAT_W), .CNT_W(CNT_W), .SUM_W(SUM_W_B), .HOLD_CYC(HOLD_CYC)
    ) u_dut_b (
        .clk(clk), .reset(reset),
        .sample_valid(b_valid), .sample_lat(b_lat),
        .clear(b_clear), .snap_req(b_req),
        .snap_busy(b_busy), .snap_min(b_min), .snap_max(b_max),
        .snap_sum(b_sum), .snap_cnt(b_cnt), .snap_sat(b_sat), .snap_seq(b_seq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model of DUT A
    logic [LAT_W-1:0] m_min, m_max;
    logic [SUM_W-1:0] m_sum;
    logic [CNT_W-1:0] m_cnt;
    logic             m_sat;
    logic [SEQ_W-1:0] m_seq;
    int               m_hold;
    snap_t            m_snap;
    snap_t            exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_live_init();
        m_min = '1;
        m_max = '0;
        m_sum = '0;
        m_cnt = '0;
        m_sat = 1'b0;
    endtask

    task automatic model_reset();
        model_live_init();
        m_seq      = '0;
        m_hold     = 0;
        m_snap.mn  = '0;
        m_snap.mx  = '0;
        m_snap.sum = '0;
        m_snap.cnt = '0;
        m_snap.sat = 1'b0;
        m_snap.seq = '0;
        exp_q.delete();
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_busy"}, 64'(a_busy), 64'(m_hold != 0));
        check({tag, "_min"},  64'(a_min),  64'(m_snap.mn));
        check({tag, "_max"},  64'(a_max),  64'(m_snap.mx));
        check({tag, "_sum"},  64'(a_sum),  64'(m_snap.sum));
        check({tag, "_cnt"},  64'(a_cnt),  64'(m_snap.cnt));
        check({tag, "_sat"},  64'(a_sat),  64'(m_snap.sat));
        check({tag, "_seq"},  64'(a_seq),  64'(m_snap.seq));
    endtask

    // One clock of DUT A: drive, predict, clock, compare. Called at posedge+1.
    task automatic tick(input logic sv, input logic [LAT_W-1:0] lat,
                        input logic clr, input logic req);
        logic             accept;
        logic [SUM_W:0]   full;
        logic [LAT_W-1:0] nmin, nmax;
        logic [SUM_W-1:0] nsum;
        logic [CNT_W-1:0] ncnt;
        logic             nsat;
        snap_t            s;

        a_valid = sv;
        a_lat   = lat;
        a_clear = clr;
        a_req   = req;

        accept = (m_hold == 0) && req && !clr;
        nmin = m_min;
        nmax = m_max;
        nsum = m_sum;
        ncnt = m_cnt;
        nsat = m_sat;
        if (sv) begin
            if (m_cnt == {CNT_W{1'b1}}) nsat = 1'b1;
            else                        ncnt = m_cnt + CNT_W'(1);
            full = {1'b0, m_sum} + (SUM_W+1)'(lat);
            if (full > {1'b0, {SUM_W{1'b1}}}) begin
                nsum = '1;
                nsat = 1'b1;
            end else begin
                nsum = full[SUM_W-1:0];
            end
            if (lat < nmin) nmin = lat;
            if (lat > nmax) nmax = lat;
        end
        if (accept) begin
            s.cnt = ncnt;
            s.sum = nsum;
            s.sat = nsat;
            s.mn  = (ncnt == '0) ? '0 : nmin;
            s.mx  = (ncnt == '0) ? '0 : nmax;
            s.seq = m_seq + SEQ_W'(1);
            exp_q.push_back(s);
        end

        @(posedge clk);
        #1;

        if (clr || accept) begin
            model_live_init();
        end else begin
            m_min = nmin;
            m_max = nmax;
            m_sum = nsum;
            m_cnt = ncnt;
            m_sat = nsat;
        end
        if (accept) begin
            m_seq  = m_seq + SEQ_W'(1);
            m_hold = HOLD_CYC;
        end else if (m_hold > 0) begin
            m_hold--;
        end
        if (exp_q.size() > 0) m_snap = exp_q.pop_front();
        compare_all("tick");

        a_valid = 1'b0;
        a_lat   = '0;
        a_clear = 1'b0;
        a_req   = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i <= HOLD_CYC && m_hold != 0; i++) tick(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        a_valid = 1'b0; a_lat = '0; a_clear = 1'b0; a_req = 1'b0;
        b_valid = 1'b0; b_lat = '0; b_clear = 1'b0; b_req = 1'b0;
        reset = 1'b1;
        model_reset();

        // Reset state
        #1;
        compare_all("reset");
        check("reset_b_busy", 64'(b_busy), 64'd0);
        check("reset_b_sum",  64'(b_sum),  64'd0);
        check("reset_b_seq",  64'(b_seq),  64'd0);
        #12 reset = 1'b0;
        @(posedge clk);
        #1;

        // Samples 5, 3, 9 then snapshot
        tick(1'b1, 16'd5, 1'b0, 1'b0);
        tick(1'b1, 16'd3, 1'b0, 1'b0);
        tick(1'b1, 16'd9, 1'b0, 1'b0);
        tick(1'b0, '0,    1'b0, 1'b1);
        check("t1_min",  64'(a_min),  64'd3);
        check("t1_max",  64'(a_max),  64'd9);
        check("t1_sum",  64'(a_sum),  64'd17);
        check("t1_cnt",  64'(a_cnt),  64'd3);
        check("t1_sat",  64'(a_sat),  64'd0);
        check("t1_seq",  64'(a_seq),  64'd1);
        check("t1_busy", 64'(a_busy), 64'd1);

        // snap_req during HOLD is dropped
        repeat (4) tick(1'b0, '0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b1);
        check("hold_req_seq", 64'(a_seq), 64'd1);
        check("hold_req_sum", 64'(a_sum), 64'd17);

        // Request on the first cycle after busy falls is accepted
        wait_idle();
        check("post_hold_busy", 64'(a_busy), 64'd0);
        tick(1'b0, '0, 1'b0, 1'b1);
        check("t2_seq", 64'(a_seq), 64'd2);
        check("t2_cnt", 64'(a_cnt), 64'd0);
        check("t2_min", 64'(a_min), 64'd0);
        check("t2_max", 64'(a_max), 64'd0);
        wait_idle();

        // Sample coincident with snap_req is included
        tick(1'b1, 16'd2, 1'b0, 1'b0);
        tick(1'b1, 16'd4, 1'b0, 1'b0);
        tick(1'b1, 16'd7, 1'b0, 1'b1);
        check("coin_cnt", 64'(a_cnt), 64'd3);
        check("coin_sum", 64'(a_sum), 64'd13);
        check("coin_max", 64'(a_max), 64'd7);
        check("coin_min", 64'(a_min), 64'd2);
        check("coin_seq", 64'(a_seq), 64'd3);
        wait_idle();
        tick(1'b0, '0, 1'b0, 1'b1);
        check("empty_cnt", 64'(a_cnt), 64'd0);
        check("empty_min", 64'(a_min), 64'd0);
        check("empty_max", 64'(a_max), 64'd0);
        check("empty_seq", 64'(a_seq), 64'd4);
        wait_idle();

        // clear wins over snap_req
        tick(1'b1, 16'd10, 1'b0, 1'b0);
        tick(1'b1, 16'd20, 1'b0, 1'b0);
        tick(1'b1, 16'd30, 1'b0, 1'b0);
        tick(1'b1, 16'd40, 1'b0, 1'b0);
        tick(1'b1, 16'd50, 1'b1, 1'b1);
        check("clr_req_seq",  64'(a_seq),  64'd4);
        check("clr_req_busy", 64'(a_busy), 64'd0);
        check("clr_req_cnt",  64'(a_cnt),  64'd0);
        tick(1'b0, '0, 1'b0, 1'b1);
        check("after_clr_cnt", 64'(a_cnt), 64'd0);
        check("after_clr_seq", 64'(a_seq), 64'd5);

        // clear alone during HOLD: coincident sample discarded, HOLD length kept
        tick(1'b1, 16'd100, 1'b0, 1'b0);
        tick(1'b1, 16'd6,   1'b1, 1'b0);
        tick(1'b1, 16'd8,   1'b0, 1'b0);
        wait_idle();
        tick(1'b0, '0, 1'b0, 1'b1);
        check("clr_hold_cnt", 64'(a_cnt), 64'd1);
        check("clr_hold_min", 64'(a_min), 64'd8);
        check("clr_hold_max", 64'(a_max), 64'd8);
        check("clr_hold_sum", 64'(a_sum), 64'd8);
        check("clr_hold_seq", 64'(a_seq), 64'd6);

        // Asynchronous reset in the middle of HOLD
        repeat (3) tick(1'b0, '0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_min",  64'(a_min),  64'd0);
        check("rst_max",  64'(a_max),  64'd0);
        check("rst_sum",  64'(a_sum),  64'd0);
        check("rst_cnt",  64'(a_cnt),  64'd0);
        check("rst_sat",  64'(a_sat),  64'd0);
        check("rst_seq",  64'(a_seq),  64'd0);
        model_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        tick(1'b0, '0, 1'b0, 1'b1);
        check("rst_rel_seq",  64'(a_seq),  64'd1);
        check("rst_rel_busy", 64'(a_busy), 64'd1);
        check("rst_rel_cnt",  64'(a_cnt),  64'd0);

        // Sum saturation on the narrow instance (SUM_W = 18)
        b_valid = 1'b1;
        b_lat   = 16'hFFFF;
        repeat (5) @(posedge clk);
        #1;
        b_valid = 1'b0;
        b_req   = 1'b1;
        @(posedge clk);
        #1;
        b_req = 1'b0;
        check("bsat_sum", 64'(b_sum), 64'd262143);
        check("bsat_cnt", 64'(b_cnt), 64'd5);
        check("bsat_sat", 64'(b_sat), 64'd1);
        check("bsat_max", 64'(b_max), 64'd65535);
        check("bsat_min", 64'(b_min), 64'd65535);
        check("bsat_seq", 64'(b_seq), 64'd1);
        repeat (HOLD_CYC) @(posedge clk);
        #1;
        check("bsat_busy_end", 64'(b_busy), 64'd0);
        b_valid = 1'b1;
        b_lat   = 16'd1;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        b_req   = 1'b1;
        @(posedge clk);
        #1;
        b_req = 1'b0;
        check("bnext_sat", 64'(b_sat), 64'd0);
        check("bnext_sum", 64'(b_sum), 64'd1);
        check("bnext_cnt", 64'(b_cnt), 64'd1);
        check("bnext_seq", 64'(b_seq), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
